vdp_cpu_bridge: RTL and testbench

Converts the raw Z80 I/O strobes for the VDP ports ($98–$9B) into clean, single-shot VDP bus requests. It sits between the board pins (decoded `csr_n`/`csw_n`, `mode[1:0]`, `cd[7:0]`) and the VDP core's `REQ/WRT/ADR/DBO` inputs, running entirely in the 27 MHz pixel clock domain. It replaces ad-hoc strobe handling with synchronisation, glitch filtering, and a request state machine that fires exactly once per CPU access.

---
 rtl/vdp_cpu_bridge.sv | 158 +++++++++++++++
 tb/tb_vdp_cpu_bridge.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vdp_cpu_bridge.sv
// Z80 -> VDP port bridge: synchronises and glitch-filters the raw I/O strobes and
// issues exactly one VDP request per CPU access. Optional ack handshake: VDP_BRIDGE_ACK_EN.
module vdp_cpu_bridge #(
   parameter int FILTER_LEN  = 3,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        csr_n,
   input  logic        csw_n,
   input  logic [1:0]  mode,
   input  logic [7:0]  cd_in,
   input  logic        ack,
   output logic        req,
   output logic        wrt,
   output logic [15:0] adr,
   output logic [7:0]  dbo,
   output logic        busy,
   output logic        protocol_err
);

   localparam int CW = 4;

`ifdef VDP_BRIDGE_ACK_EN
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_HOLD} state_t;
   logic [7:0] tmo_q, tmo_d;
`else
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;
   logic unused_ack;
   assign unused_ack = ack;
`endif

   state_t        state_q, state_d;
   logic [1:0]    raw;                 // [0] read strobe, [1] write strobe
   logic [1:0]    s1_q, s2_q, filt_q, filt_d;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [1:0]    mode_s1_q, mode_s2_q;
   logic [7:0]    cd_s1_q, cd_s2_q;
   logic [15:0]   adr_q, adr_d;
   logic [7:0]    dbo_q, dbo_d;
   logic          wr_q, wr_d, err_q, err_d;

   assign raw = {csw_n, csr_n};

   // The counter tracks the first-stage sample so the filtered strobe lands
   // FILTER_LEN edges after it; the flip also needs the second stage to agree.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         cnt_d[i]  = '0;
         filt_d[i] = filt_q[i];
         if (s1_q[i] != filt_q[i]) begin
            if (cnt_q[i] >= CW'(FILTER_LEN - 1) && s2_q[i] != filt_q[i])
               filt_d[i] = ~filt_q[i];
            else if (cnt_q[i] < CW'(FILTER_LEN - 1))
               cnt_d[i] = cnt_q[i] + 1'b1;
            else
               cnt_d[i] = cnt_q[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dbo_d   = dbo_q;
      wr_d    = wr_q;
      err_d   = 1'b0;
`ifdef VDP_BRIDGE_ACK_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (filt_q == 2'b00) begin
               err_d   = 1'b1;
               state_d = S_HOLD;
            end else if (filt_q != 2'b11) begin
               adr_d   = {14'b0, mode_s2_q};
               wr_d    = ~filt_q[1];
               if (~filt_q[1]) dbo_d = cd_s2_q;
               state_d = S_ISSUE;
            end
         end
`ifdef VDP_BRIDGE_ACK_EN
         S_ISSUE: begin
            tmo_d   = '0;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (ack) begin
               state_d = S_HOLD;
            end else if (tmo_q >= 8'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_HOLD;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
`else
         S_ISSUE: state_d = S_HOLD;
`endif
         S_HOLD: if (filt_q == 2'b11) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_q      <= 2'b11;
         s2_q      <= 2'b11;
         filt_q    <= 2'b11;
         cnt_q[0]  <= '0;
         cnt_q[1]  <= '0;
         mode_s1_q <= '0;
         mode_s2_q <= '0;
         cd_s1_q   <= '0;
         cd_s2_q   <= '0;
         state_q   <= S_IDLE;
         adr_q     <= '0;
         dbo_q     <= '0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
`ifdef VDP_BRIDGE_ACK_EN
         tmo_q     <= '0;
`endif
      end else begin
         s1_q      <= raw;
         s2_q      <= s1_q;
         filt_q    <= filt_d;
         cnt_q[0]  <= cnt_d[0];
         cnt_q[1]  <= cnt_d[1];
         mode_s1_q <= mode;
         mode_s2_q <= mode_s1_q;
         cd_s1_q   <= cd_in;
         cd_s2_q   <= cd_s1_q;
         state_q   <= state_d;
         adr_q     <= adr_d;
         dbo_q     <= dbo_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
`ifdef VDP_BRIDGE_ACK_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

`ifdef VDP_BRIDGE_ACK_EN
   assign req = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
`else
   assign req = (state_q == S_ISSUE);
`endif
   assign wrt          = req & wr_q;
   assign adr          = adr_q;
   assign dbo          = dbo_q;
   assign busy         = (state_q != S_IDLE);
   assign protocol_err = err_q;

endmodule

// File: tb/tb_vdp_cpu_bridge.sv
// Directed bench for vdp_cpu_bridge (default build, FILTER_LEN = 3).
module tb_vdp_cpu_bridge;

   logic        clk = 1'b0, reset_n = 1'b0, csr_n = 1'b1, csw_n = 1'b1, ack = 1'b0;
   logic [1:0]  mode = '0;
   logic [7:0]  cd_in = '0;
   logic        req, wrt, busy, protocol_err;
   logic [15:0] adr;
   logic [7:0]  dbo;

   int n_chk = 0, n_err = 0;
   int req_cyc = 0, err_cyc = 0, busy_cyc = 0;

   vdp_cpu_bridge dut (
      .clk(clk), .reset_n(reset_n), .csr_n(csr_n), .csw_n(csw_n),
      .mode(mode), .cd_in(cd_in), .ack(ack),
      .req(req), .wrt(wrt), .adr(adr), .dbo(dbo),
      .busy(busy), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (req)          req_cyc++;
      if (protocol_err) err_cyc++;
      if (busy)         busy_cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr();
      req_cyc  = 0;
      err_cyc  = 0;
      busy_cyc = 0;
   endtask

   initial begin
      step(3);
      chk("rst_req", req, 0);
      chk("rst_wrt", wrt, 0);
      chk("rst_adr", adr, 0);
      chk("rst_dbo", dbo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", protocol_err, 0);
      reset_n = 1'b1;
      step(2);

      // write, strobe low 20 cycles
      clr();
      csw_n = 1'b0; mode = 2'b01; cd_in = 8'hA5;
      step(4);
      chk("wr_early_req", req, 0);
      step(1);
      chk("wr_req", req, 1);
      chk("wr_wrt", wrt, 1);
      chk("wr_adr", adr, 16'h0001);
      chk("wr_dbo", dbo, 8'hA5);
      chk("wr_busy", busy, 1);
      step(1);
      chk("wr_req_width", req, 0);
      step(14);
      csw_n = 1'b1;
      step(4);
      chk("wr_busy_hold", busy, 1);
      step(1);
      chk("wr_busy_fall", busy, 0);
      chk("wr_req_count", req_cyc, 1);
      chk("wr_err_count", err_cyc, 0);

      // read, dbo keeps the write data
      clr();
      csr_n = 1'b0; mode = 2'b11; cd_in = 8'h3C;
      step(4);
      chk("rd_early_req", req, 0);
      step(1);
      chk("rd_req", req, 1);
      chk("rd_wrt", wrt, 0);
      chk("rd_adr", adr, 16'h0003);
      chk("rd_dbo", dbo, 8'hA5);
      step(15);
      csr_n = 1'b1;
      step(6);
      chk("rd_busy_fall", busy, 0);
      chk("rd_req_count", req_cyc, 1);
      chk("rd_err_count", err_cyc, 0);

      // 2-cycle glitch on the write strobe
      clr();
      csw_n = 1'b0; cd_in = 8'h77;
      step(2);
      csw_n = 1'b1;
      step(8);
      chk("gl_req_count", req_cyc, 0);
      chk("gl_busy_count", busy_cyc, 0);
      chk("gl_err_count", err_cyc, 0);
      chk("gl_dbo", dbo, 8'hA5);

      // both strobes low together
      clr();
      csr_n = 1'b0; csw_n = 1'b0;
      step(10);
      chk("both_busy", busy, 1);
      csr_n = 1'b1; csw_n = 1'b1;
      step(6);
      chk("both_err_count", err_cyc, 1);
      chk("both_req_count", req_cyc, 0);
      chk("both_busy_fall", busy, 0);

      // reset asserted on the edge the request would rise
      clr();
      csw_n = 1'b0; mode = 2'b10; cd_in = 8'h5A;
      step(4);
      reset_n = 1'b0;
      step(1);
      chk("mid_rst_req", req, 0);
      chk("mid_rst_wrt", wrt, 0);
      chk("mid_rst_adr", adr, 0);
      chk("mid_rst_dbo", dbo, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", protocol_err, 0);
      csw_n = 1'b1;
      step(1);
      reset_n = 1'b1;
      step(10);
      chk("post_rst_req_count", req_cyc, 0);
      chk("post_rst_busy_count", busy_cyc, 0);

      // fresh write after reset
      clr();
      csw_n = 1'b0;
      step(4);
      chk("fresh_early_req", req, 0);
      step(1);
      chk("fresh_req", req, 1);
      chk("fresh_wrt", wrt, 1);
      chk("fresh_adr", adr, 16'h0002);
      chk("fresh_dbo", dbo, 8'h5A);
      step(15);
      csw_n = 1'b1;
      step(6);
      chk("fresh_busy_fall", busy, 0);
      chk("fresh_req_count", req_cyc, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
